// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: RV32 IF stage with a sequential prefetcher, a DEPTH-entry PC/instruction queue and branch redirect.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue goes straight to IF/ID in the same cycle.
module fetch_prefetch_queue #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_pc,
    input  logic            mux_sel,
    input  logic [XLEN-1:0] pc_branch_value,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            if_id_valid,
    input  logic            if_id_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [ILEN-1:0] instrucao
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    // stale responses from several back-to-back redirects can stack up beyond DEPTH
    localparam int DW = CW + 4;

    logic [XLEN-1:0] fetch_pc, rsp_pc, pc_hold, target;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [ILEN-1:0] ins_mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   occ, outstanding;
    logic [DW-1:0]   discard;
    logic            take, rsp_live, bypass, push, pop, has_head;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign target = pc_branch_value & ~XLEN'(3);
    assign has_head = occ != '0;
    assign imem_req_valid = reset & load_pc & ~mux_sel
                          & (SW'(occ) + SW'(outstanding) < SW'(DEPTH))
                          & (outstanding < CW'(MAX_OUTSTANDING));
    assign imem_addr = fetch_pc;
    assign take = imem_req_valid & imem_req_ready;
    assign rsp_live = reset & imem_rsp_valid & (discard == '0) & ~mux_sel;
`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_live & ~has_head & if_id_ready;
`else
    assign bypass = 1'b0;
`endif
    assign push = rsp_live & ~bypass;
    assign pop = has_head & if_id_ready;
    assign if_id_valid = has_head | bypass;
    assign pc_out = has_head ? pc_mem[head] : bypass ? rsp_pc : pc_hold;
    assign instrucao = has_head ? ins_mem[head] : bypass ? imem_rsp_data : NOP_INSTR;

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[tail] <= rsp_pc;
            ins_mem[tail] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            pc_hold <= '0;
            head <= '0;
            tail <= '0;
            occ <= '0;
            outstanding <= '0;
            discard <= '0;
        end else begin
            pc_hold <= pc_out;
            if (mux_sel) begin
                fetch_pc <= target;
                rsp_pc <= target;
                head <= '0;
                tail <= '0;
                occ <= '0;
                outstanding <= '0;
                discard <= discard + DW'(outstanding) - DW'(imem_rsp_valid);
            end else begin
                if (take)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (push | bypass)
                    rsp_pc <= rsp_pc + XLEN'(4);
                if (push)
                    tail <= nxt(tail);
                if (pop)
                    head <= nxt(head);
                occ <= occ + CW'(push) - CW'(pop);
                outstanding <= outstanding + CW'(take) - CW'(rsp_live);
                if (imem_rsp_valid && discard != '0)
                    discard <= discard - DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: randomized bench; expected PC stream and request addresses come from a stream model,
// a monitor on the falling edge compares everything the DUT presents.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int MAXO = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {logic [31:0] addr; int due; int epoch;} req_t;

    logic clock = 1'b0, reset = 1'b0;
    logic load_pc = 1'b1, mux_sel = 1'b0, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0, if_id_ready = 1'b1;
    logic [31:0] pc_branch_value = '0, imem_rsp_data = '0;
    logic imem_req_valid, if_id_valid;
    logic [31:0] imem_addr, pc_out, instrucao;

    fetch_prefetch_queue dut (
        .clock(clock), .reset(reset), .load_pc(load_pc), .mux_sel(mux_sel),
        .pc_branch_value(pc_branch_value), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
        .pc_out(pc_out), .instrucao(instrucao)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    req_t pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc = '0, exp_addr = '0, last_pc = '0, prev_target = '0, redir_tgt = '0;
    int cyc = 0, epoch = 0, rsp_epoch = 0, live_pend = 0, occ_est = 0, last_due = 0, delivered = 0;
    int p_rdy = 100, p_id = 100, p_load = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit in_reset = 1'b1, prev_redir = 1'b0, was_redir = 1'b0, redir_now = 1'b0, redir_on_rsp = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: memory model responses, control inputs, and the expected delivery stream
    always @(posedge clock) begin
        #1;
        cyc++;
        if (prev_redir) begin
            exp_q.delete();
            gen_pc = prev_target & ~32'd3;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc += 32'd4;
        end
        if (!in_reset) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = $urandom;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = word_of(pend[0].addr);
                rsp_epoch = pend[0].epoch;
                pend.pop_front();
            end
            imem_req_ready = pct(p_rdy);
            if_id_ready = pct(p_id);
            load_pc = pct(p_load);
            mux_sel = pct(p_redir);
            pc_branch_value = $urandom;
            if (redir_now) begin
                mux_sel = 1'b1;
                pc_branch_value = redir_tgt;
                redir_now = 1'b0;
            end
            if (redir_on_rsp && imem_rsp_valid) begin
                mux_sel = 1'b1;
                if_id_ready = 1'b1;
                pc_branch_value = redir_tgt;
                redir_on_rsp = 1'b0;
            end
        end
        prev_redir = mux_sel;
        prev_target = pc_branch_value;
    end

    // monitor: compares presented instructions, requests and credit use against the model
    always @(negedge clock) begin
        if (in_reset) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_addr", imem_addr, 32'd0);
            chk("rst_valid", 32'(if_id_valid), 32'd0);
            chk("rst_pc", pc_out, 32'd0);
            chk("rst_instr", instrucao, NOP);
        end else begin
            if (was_redir)
                chk("valid_after_redirect", 32'(if_id_valid), 32'd0);
            if (if_id_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_stream_empty", 32'd1, 32'd0);
                end else begin
                    chk("pc_out", pc_out, exp_q[0]);
                    chk("instrucao", instrucao, word_of(exp_q[0]));
                    last_pc = exp_q[0];
                    if (if_id_ready) begin
                        exp_q.pop_front();
                        occ_est--;
                        delivered++;
                    end
                end
            end else begin
                chk("idle_instr", instrucao, NOP);
                chk("idle_pc_hold", pc_out, last_pc);
            end
            if (imem_rsp_valid && rsp_epoch == epoch && !mux_sel) begin
                live_pend--;
                occ_est++;
            end
            if (mux_sel || !load_pc)
                chk("req_blocked", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                int due;
                chk("imem_addr", imem_addr, exp_addr);
                exp_addr += 32'd4;
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due)
                    due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: imem_addr, due: due, epoch: epoch});
                live_pend++;
                chk("max_outstanding", 32'(live_pend <= MAXO), 32'd1);
                chk("credit", 32'(live_pend + occ_est <= DEPTH), 32'd1);
            end
            if (mux_sel) begin
                epoch++;
                live_pend = 0;
                occ_est = 0;
                exp_addr = pc_branch_value & ~32'd3;
            end
        end
        was_redir = mux_sel && !in_reset;
    end

    initial begin
        int d0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        in_reset = 1'b0;
        repeat (6) @(posedge clock);
        repeat (16) begin
            @(negedge clock);
            chk("stream_no_gap", 32'(if_id_valid), 32'd1);
        end
        @(posedge clock);
        p_id = 0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("stall_full", 32'(occ_est), 32'(DEPTH));
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        @(posedge clock);
        p_id = 100;
        repeat (10) @(posedge clock);
        lat_min = 3;
        lat_max = 3;
        repeat (8) @(posedge clock);
        redir_tgt = 32'h00000012;
        redir_now = 1'b1;
        repeat (15) @(posedge clock);
        lat_min = 1;
        lat_max = 1;
        redir_tgt = 32'h00000100;
        redir_on_rsp = 1'b1;
        repeat (12) @(posedge clock);
        p_load = 0;
        repeat (8) @(posedge clock);
        redir_tgt = 32'hFFFFFFF1;
        redir_now = 1'b1;
        @(posedge clock);
        p_load = 100;
        repeat (20) @(posedge clock);
        p_rdy = 70;
        p_id = 70;
        p_load = 90;
        p_redir = 4;
        lat_max = 4;
        repeat (3000) @(posedge clock);
        p_rdy = 100;
        p_id = 100;
        p_load = 100;
        p_redir = 0;
        d0 = delivered;
        for (int i = 0; i < 200 && delivered < d0 + 20; i++)
            @(posedge clock);
        chk("drain_progress", 32'(delivered >= d0 + 20), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
